// File: rtl/ram_port_arbiter_pkg.sv
// Shared constants for the instruction/data RAM port arbiter.
// Owner encodings describe who the word returning from RAM belongs to.
package ram_port_arbiter_pkg;

    localparam logic [1:0] OWN_IDLE    = 2'd0;
    localparam logic [1:0] OWN_INSTR   = 2'd1;
    localparam logic [1:0] OWN_DATA_RD = 2'd2;
    localparam logic [1:0] OWN_DATA_WR = 2'd3;

    localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/ram_port_arbiter_starve_counter.sv
// Saturating count of data grants taken while a fetch is waiting.
// Ports: clk/rst, inc (count one), clr (restart), sat (at MAX), cnt.
module starve_counter #(
    parameter int MAX = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       inc,
    input  logic                       clr,
    output logic                       sat,
    output logic [$clog2(MAX+1)-1:0]   cnt
);

    localparam int W = $clog2(MAX + 1);

    assign sat = (cnt == W'(MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one synchronous-read RAM port between fetch and load/store.
// Ports: sysClk/sysRes, instr* fetch side, data* load/store side, ram* RAM.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                sysClk,
    input  logic                sysRes,
    input  logic                instrReq,
    input  logic [ADDR_W-1:0]   instrAddr,
    output logic                instrGnt,
    output logic                instrValid,
    output logic [DATA_W-1:0]   instrData,
    input  logic                dataReq,
    input  logic                dataWe,
    input  logic [DATA_W/8-1:0] dataMask,
    input  logic [ADDR_W-1:0]   dataAddr,
    input  logic [DATA_W-1:0]   dataWData,
    output logic                dataGnt,
    output logic                dataValid,
    output logic [DATA_W-1:0]   dataRData,
    output logic                ramEn,
    output logic [DATA_W/8-1:0] ramWe,
    output logic [ADDR_W-1:0]   ramAddr,
    output logic [DATA_W-1:0]   ramWData,
    input  logic [DATA_W-1:0]   ramRData
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    logic          sat;
    logic [CW-1:0] starveCnt;
    logic [1:0]    owner;
    logic [1:0]    owner_d;

    // Data wins unless the fetch side has been passed over too often.
    always_comb begin
        instrGnt = 1'b0;
        dataGnt  = 1'b0;
        if (!sysRes) begin
            instrGnt = instrReq && (!dataReq || sat);
            dataGnt  = dataReq && !instrGnt;
        end
    end

    always_comb begin
        ramEn    = 1'b0;
        ramWe    = '0;
        ramAddr  = '0;
        ramWData = '0;
        owner_d  = OWN_IDLE;
        unique case (1'b1)
            instrGnt: begin
                ramEn   = 1'b1;
                ramAddr = instrAddr;
                owner_d = OWN_INSTR;
            end
            dataGnt: begin
                ramEn    = 1'b1;
                ramAddr  = dataAddr;
                ramWData = dataWData;
                if (dataWe) begin
                    ramWe   = dataMask;
                    owner_d = OWN_DATA_WR;
                end else begin
                    owner_d = OWN_DATA_RD;
                end
            end
            default: ;
        endcase
    end

    // Owner follows the RAM's one-cycle read latency.
    always_ff @(posedge sysClk) begin
        if (sysRes) begin
            owner <= OWN_IDLE;
        end else begin
            owner <= owner_d;
        end
    end

    assign instrValid = (owner == OWN_INSTR);
    assign instrData  = instrValid ? ramRData : '0;
    assign dataValid  = (owner == OWN_DATA_RD) || (owner == OWN_DATA_WR);
    assign dataRData  = (owner == OWN_DATA_RD) ? ramRData : '0;

    starve_counter #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk (sysClk),
        .rst (sysRes),
        .inc (dataGnt && instrReq),
        .clr (instrGnt || !instrReq),
        .sat (sat),
        .cnt (starveCnt)
    );

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a small RAM model.
// Inputs change 1ns after posedge; outputs are checked on negedge.
module tb_ram_port_arbiter;
    import ram_port_arbiter_pkg::*;

    logic        sysClk = 1'b0;
    logic        sysRes;
    logic        instrReq;
    logic [31:0] instrAddr;
    logic        instrGnt;
    logic        instrValid;
    logic [31:0] instrData;
    logic        dataReq;
    logic        dataWe;
    logic [3:0]  dataMask;
    logic [31:0] dataAddr;
    logic [31:0] dataWData;
    logic        dataGnt;
    logic        dataValid;
    logic [31:0] dataRData;
    logic        ramEn;
    logic [3:0]  ramWe;
    logic [31:0] ramAddr;
    logic [31:0] ramWData;
    logic [31:0] ramRData;

    logic [31:0] mem [0:255];

    int errs   = 0;
    int checks = 0;

    always #5 sysClk = ~sysClk;

    ram_port_arbiter dut (
        .sysClk     (sysClk),
        .sysRes     (sysRes),
        .instrReq   (instrReq),
        .instrAddr  (instrAddr),
        .instrGnt   (instrGnt),
        .instrValid (instrValid),
        .instrData  (instrData),
        .dataReq    (dataReq),
        .dataWe     (dataWe),
        .dataMask   (dataMask),
        .dataAddr   (dataAddr),
        .dataWData  (dataWData),
        .dataGnt    (dataGnt),
        .dataValid  (dataValid),
        .dataRData  (dataRData),
        .ramEn      (ramEn),
        .ramWe      (ramWe),
        .ramAddr    (ramAddr),
        .ramWData   (ramWData),
        .ramRData   (ramRData)
    );

    function automatic logic [31:0] init_word(int idx);
        if (idx == 4)                 return 32'h0000_0013;
        if (idx == 32)                return 32'hDEAD_BEEF;
        if (idx >= 64 && idx <= 103)  return 32'h1000_0000 | (idx << 2);
        return 32'h0;
    endfunction

    // Synchronous-read RAM; contents reload while reset is held.
    always @(posedge sysClk) begin
        if (sysRes) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            ramRData <= 32'h0;
        end else if (ramEn) begin
            ramRData <= mem[ramAddr[9:2]];
            for (int b = 0; b < 4; b++) begin
                if (ramWe[b]) mem[ramAddr[9:2]][b*8 +: 8] <= ramWData[b*8 +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysClk);
        #1;
    endtask

    task automatic idle();
        instrReq = 1'b0;
        dataReq  = 1'b0;
        dataWe   = 1'b0;
    endtask

    initial begin
        sysRes    = 1'b1;
        instrReq  = 1'b1;
        instrAddr = 32'h10;
        dataReq   = 1'b1;
        dataWe    = 1'b1;
        dataMask  = 4'hF;
        dataAddr  = 32'h80;
        dataWData = 32'h1234_5678;

        // reset holds everything off even with requests pending
        @(negedge sysClk);
        chk("rst_igt", instrGnt, 0);
        chk("rst_dgt", dataGnt, 0);
        chk("rst_en", ramEn, 0);
        chk("rst_we", ramWe, 0);
        tick();
        tick();
        sysRes = 1'b0;
        idle();
        @(negedge sysClk);
        chk("rst_iv", instrValid, 0);
        chk("rst_dv", dataValid, 0);
        chk("rst_own", dut.owner, OWN_IDLE);
        chk("rst_cnt", dut.starveCnt, 0);
        chk("idle_addr", ramAddr, 0);
        chk("idle_wd", ramWData, 0);
        tick();

        // fetch alone
        instrReq  = 1'b1;
        instrAddr = 32'h10;
        @(negedge sysClk);
        chk("f_gnt", instrGnt, 1);
        chk("f_dgnt", dataGnt, 0);
        chk("f_en", ramEn, 1);
        chk("f_addr", ramAddr, 32'h10);
        chk("f_we", ramWe, 0);
        tick();
        idle();
        @(negedge sysClk);
        chk("f_iv", instrValid, 1);
        chk("f_id", instrData, 32'h13);
        chk("f_dv", dataValid, 0);
        chk("f_en0", ramEn, 0);
        tick();
        @(negedge sysClk);
        chk("f_iv0", instrValid, 0);
        chk("f_id0", instrData, 0);
        tick();

        // collision: data first, fetch next
        instrReq = 1'b1;
        dataReq  = 1'b1;
        dataWe   = 1'b0;
        dataAddr = 32'h80;
        @(negedge sysClk);
        chk("c_dgnt", dataGnt, 1);
        chk("c_igt", instrGnt, 0);
        chk("c_addr", ramAddr, 32'h80);
        chk("c_we", ramWe, 0);
        tick();
        dataReq = 1'b0;
        @(negedge sysClk);
        chk("c_dv", dataValid, 1);
        chk("c_rd", dataRData, 32'hDEAD_BEEF);
        chk("c_iv", instrValid, 0);
        chk("c_igt2", instrGnt, 1);
        chk("c_cnt1", dut.starveCnt, 1);
        tick();
        idle();
        @(negedge sysClk);
        chk("c_iv2", instrValid, 1);
        chk("c_id", instrData, 32'h13);
        chk("c_cnt0", dut.starveCnt, 0);
        tick();

        // byte store
        dataReq   = 1'b1;
        dataWe    = 1'b1;
        dataMask  = 4'b0010;
        dataWData = 32'hAABB_CCDD;
        dataAddr  = 32'h40;
        @(negedge sysClk);
        chk("s_gnt", dataGnt, 1);
        chk("s_we", ramWe, 4'b0010);
        chk("s_wd", ramWData, 32'hAABB_CCDD);
        chk("s_addr", ramAddr, 32'h40);
        tick();
        idle();
        @(negedge sysClk);
        chk("s_dv", dataValid, 1);
        chk("s_rd", dataRData, 0);
        chk("s_mem", mem[16], 32'h0000_CC00);
        tick();

        // load back the stored word
        dataReq  = 1'b1;
        dataAddr = 32'h40;
        @(negedge sysClk);
        chk("lb_gnt", dataGnt, 1);
        chk("lb_we", ramWe, 0);
        tick();
        idle();
        @(negedge sysClk);
        chk("lb_dv", dataValid, 1);
        chk("lb_rd", dataRData, 32'h0000_CC00);
        tick();

        // starvation: 4 data grants, 1 fetch, then data again
        instrReq  = 1'b1;
        instrAddr = 32'h10;
        dataReq   = 1'b1;
        dataWe    = 1'b0;
        dataAddr  = 32'h80;
        for (int k = 0; k < 4; k++) begin
            @(negedge sysClk);
            chk($sformatf("sv_dgnt%0d", k), dataGnt, 1);
            chk($sformatf("sv_igt%0d", k), instrGnt, 0);
            chk($sformatf("sv_cnt%0d", k), dut.starveCnt, k);
            if (k > 0) chk($sformatf("sv_rd%0d", k), dataRData, 32'hDEAD_BEEF);
            tick();
        end
        @(negedge sysClk);
        chk("sv_igt4", instrGnt, 1);
        chk("sv_dgnt4", dataGnt, 0);
        chk("sv_cnt4", dut.starveCnt, 4);
        chk("sv_dv4", dataValid, 1);
        tick();
        @(negedge sysClk);
        chk("sv_dgnt5", dataGnt, 1);
        chk("sv_cnt5", dut.starveCnt, 0);
        chk("sv_iv5", instrValid, 1);
        chk("sv_id5", instrData, 32'h13);
        tick();
        idle();
        @(negedge sysClk);
        chk("sv_dv6", dataValid, 1);
        chk("sv_cnt6", dut.starveCnt, 1);
        tick();
        @(negedge sysClk);
        chk("sv_cnt7", dut.starveCnt, 0);
        tick();

        // streaming: alternate fetch and load every cycle
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                instrReq  = 1'b1;
                instrAddr = 32'h100 + 32'(4 * i);
                dataReq   = 1'b0;
            end else begin
                dataReq  = 1'b1;
                dataAddr = 32'h180 + 32'(4 * i);
                instrReq = 1'b0;
            end
            @(negedge sysClk);
            if (i % 2 == 0) chk($sformatf("st_igt%0d", i), instrGnt, 1);
            else            chk($sformatf("st_dgt%0d", i), dataGnt, 1);
            if (i > 0) begin
                if ((i - 1) % 2 == 0) begin
                    chk($sformatf("st_iv%0d", i), instrValid, 1);
                    chk($sformatf("st_id%0d", i), instrData,
                        32'h1000_0100 + 32'(4 * (i - 1)));
                    chk($sformatf("st_ndv%0d", i), dataValid, 0);
                end else begin
                    chk($sformatf("st_dv%0d", i), dataValid, 1);
                    chk($sformatf("st_rd%0d", i), dataRData,
                        32'h1000_0180 + 32'(4 * (i - 1)));
                    chk($sformatf("st_niv%0d", i), instrValid, 0);
                end
            end
            tick();
        end
        idle();
        @(negedge sysClk);
        chk("st_dv8", dataValid, 1);
        chk("st_rd8", dataRData, 32'h1000_019C);
        chk("st_niv8", instrValid, 0);
        tick();

        // reset while a fetch is in flight
        instrReq  = 1'b1;
        instrAddr = 32'h10;
        @(negedge sysClk);
        chk("rm_igt", instrGnt, 1);
        tick();
        sysRes   = 1'b1;
        dataReq  = 1'b1;
        dataAddr = 32'h80;
        @(negedge sysClk);
        chk("rm_igt0", instrGnt, 0);
        chk("rm_dgt0", dataGnt, 0);
        chk("rm_en0", ramEn, 0);
        tick();
        sysRes = 1'b0;
        idle();
        @(negedge sysClk);
        chk("rm_iv", instrValid, 0);
        chk("rm_id", instrData, 0);
        chk("rm_dv", dataValid, 0);
        chk("rm_own", dut.owner, OWN_IDLE);
        chk("rm_cnt", dut.starveCnt, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
